// File: rtl/axis_frame_pad_pkg.sv
// Shared stream definitions for the transmit-path frame padder.
// Holds the default minimum frame length and FSM state encoding.
package axis_frame_pad_pkg;

  localparam int MIN_FRAME_LEN_DEF = 60;

  typedef enum logic {
    PASS = 1'b0,
    PAD  = 1'b1
  } state_t;

endpackage

// File: rtl/axis_frame_pad_if.sv
// AXI-stream bundle used on both sides of the frame padder.
// master drives payload and valid, slave drives ready.
interface axis_frame_pad_if #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/axis_frame_pad_keep_popcount.sv
// Combinational count of set tkeep bits.
// Shared by the length-aware stream blocks.
module keep_popcount #(
  parameter int KEEP_WIDTH = 1
) (
  input  logic [KEEP_WIDTH-1:0]           i_keep,
  output logic [$clog2(KEEP_WIDTH+1)-1:0] o_count
);

  localparam int CW = $clog2(KEEP_WIDTH + 1);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      o_count = o_count + CW'(i_keep[i]);
    end
  end

endmodule

// File: rtl/axis_frame_pad.sv
// Pads short AXI-stream frames with zero bytes to MIN_FRAME_LEN.
// Registered output; ready to the source is combinational.
module axis_frame_pad
  import axis_frame_pad_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int KEEP_ENABLE   = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int MIN_FRAME_LEN = MIN_FRAME_LEN_DEF
) (
  input logic              clk,
  input logic              rst,
  axis_frame_pad_if.slave  s_axis,
  axis_frame_pad_if.master m_axis
);

  localparam int CW = $clog2(MIN_FRAME_LEN + 1);
  localparam int PW = $clog2(KEEP_WIDTH + 1);
  localparam int SW = CW + PW + 1;
  localparam logic [SW-1:0] MIN_S = SW'(MIN_FRAME_LEN);
  localparam logic [SW-1:0] KW_S  = SW'(KEEP_WIDTH);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_FRAME_LEN);

  function automatic logic [KEEP_WIDTH-1:0] low_mask(
    input logic [SW-1:0] n
  );
    logic [KEEP_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      m[i] = (SW'(i) < n);
    end
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_mask(
    input logic [KEEP_WIDTH-1:0] k
  );
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      m[i*8 +: 8] = {8{k[i]}};
    end
    return m;
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic [KEEP_WIDTH-1:0] r_keep;
  logic [KEEP_WIDTH-1:0] w_keep_nxt;
  logic                  r_valid;
  logic                  w_valid_nxt;
  logic                  r_last;
  logic                  w_last_nxt;
  logic                  r_user;
  logic                  w_user_nxt;
  logic                  r_user_lat;
  logic                  w_user_lat_nxt;

  logic [KEEP_WIDTH-1:0] w_keep_in;
  logic [PW-1:0]         w_pc;
  logic                  w_load;
  logic                  w_s_ready;
  logic                  w_accept;
  logic [SW-1:0]         w_total;
  logic [SW-1:0]         w_need;
  logic [SW-1:0]         w_room;
  logic [SW-1:0]         w_fill;
  logic                  w_short;
  logic [SW-1:0]         w_rem;
  logic [CW-1:0]         w_cnt_sat;

  assign w_keep_in = (KEEP_ENABLE != 0) ? s_axis.tkeep : '1;

  keep_popcount #(
    .KEEP_WIDTH(KEEP_WIDTH)
  ) u_popcount (
    .i_keep (w_keep_in),
    .o_count(w_pc)
  );

  assign w_load    = !r_valid || m_axis.tready;
  assign w_s_ready = !rst && (r_state == PASS) && w_load;
  assign w_accept  = s_axis.tvalid && w_s_ready;

  assign w_total = SW'(r_cnt) + SW'(w_pc);
  assign w_short = w_total < MIN_S;
  assign w_need  = MIN_S - w_total;
  assign w_room  = KW_S - SW'(w_pc);
  assign w_fill  = (w_need < w_room) ? w_need : w_room;
  assign w_rem   = MIN_S - SW'(r_cnt);

  // Saturate so long frames never wrap the narrow counter
  assign w_cnt_sat = w_short ? CW'(w_total) : MIN_C;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_data_nxt     = r_data;
    w_keep_nxt     = r_keep;
    w_valid_nxt    = r_valid;
    w_last_nxt     = r_last;
    w_user_nxt     = r_user;
    w_user_lat_nxt = r_user_lat;
    unique case (r_state)
      PASS: begin
        if (w_load) begin
          w_valid_nxt = w_accept;
          if (w_accept) begin
            w_data_nxt = s_axis.tdata;
            w_keep_nxt = w_keep_in;
            w_last_nxt = s_axis.tlast;
            w_user_nxt = s_axis.tuser;
            w_cnt_nxt  = w_cnt_sat;
            if (s_axis.tlast) begin
              w_cnt_nxt = '0;
              if (w_short) begin
                w_data_nxt = s_axis.tdata
                           & lane_mask(w_keep_in);
                w_keep_nxt = low_mask(
                  SW'(w_pc) + w_fill);
                if (w_fill != w_need) begin
                  w_last_nxt     = 1'b0;
                  w_user_nxt     = 1'b0;
                  w_user_lat_nxt = s_axis.tuser;
                  w_cnt_nxt      = CW'(w_total + w_fill);
                  w_state_nxt    = PAD;
                end
              end
            end
          end
        end
      end
      PAD: begin
        if (w_load) begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = '0;
          w_keep_nxt  = '1;
          w_last_nxt  = 1'b0;
          w_user_nxt  = 1'b0;
          w_cnt_nxt   = CW'(SW'(r_cnt) + KW_S);
          if (w_rem <= KW_S) begin
            w_keep_nxt  = low_mask(w_rem);
            w_last_nxt  = 1'b1;
            w_user_nxt  = r_user_lat;
            w_cnt_nxt   = '0;
            w_state_nxt = PASS;
          end
        end
      end
      default: w_state_nxt = PASS;
    endcase
    if (KEEP_ENABLE == 0) begin
      w_keep_nxt = {KEEP_WIDTH{w_valid_nxt}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= PASS;
      r_cnt      <= '0;
      r_data     <= '0;
      r_keep     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_user     <= 1'b0;
      r_user_lat <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_data     <= w_data_nxt;
      r_keep     <= w_keep_nxt;
      r_valid    <= w_valid_nxt;
      r_last     <= w_last_nxt;
      r_user     <= w_user_nxt;
      r_user_lat <= w_user_lat_nxt;
    end
  end

  assign s_axis.tready = w_s_ready;
  assign m_axis.tdata  = r_data;
  assign m_axis.tkeep  = r_keep;
  assign m_axis.tvalid = r_valid;
  assign m_axis.tlast  = r_last;
  assign m_axis.tuser  = r_user;

endmodule

// File: tb/tb_axis_frame_pad.sv
// Bench for axis_frame_pad: three configurations share one driver.
// Expected beats come from a byte-stream model of padding.
module tb_axis_frame_pad;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  localparam int LIMIT = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] drv_data   = '0;
  logic [3:0]  drv_keep   = '0;
  logic        drv_valid  = 1'b0;
  logic        drv_last   = 1'b0;
  logic        drv_user   = 1'b0;
  logic        drv_mready = 1'b0;
  int          sel        = 0;

  logic        mon_valid;
  logic [31:0] mon_data;
  logic [3:0]  mon_keep;
  logic        mon_last;
  logic        mon_user;
  logic        mon_sready;

  beat_t in_q[$];
  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  axis_frame_pad_if #(.DATA_WIDTH(8))  s0();
  axis_frame_pad_if #(.DATA_WIDTH(8))  m0();
  axis_frame_pad_if #(.DATA_WIDTH(32)) s1();
  axis_frame_pad_if #(.DATA_WIDTH(32)) m1();
  axis_frame_pad_if #(.DATA_WIDTH(32)) s2();
  axis_frame_pad_if #(.DATA_WIDTH(32)) m2();

  assign s0.tdata  = drv_data[7:0];
  assign s0.tkeep  = drv_keep[0:0];
  assign s0.tvalid = drv_valid && (sel == 0);
  assign s0.tlast  = drv_last;
  assign s0.tuser  = drv_user;
  assign m0.tready = drv_mready;

  assign s1.tdata  = drv_data;
  assign s1.tkeep  = drv_keep;
  assign s1.tvalid = drv_valid && (sel == 1);
  assign s1.tlast  = drv_last;
  assign s1.tuser  = drv_user;
  assign m1.tready = drv_mready;

  assign s2.tdata  = drv_data;
  assign s2.tkeep  = drv_keep;
  assign s2.tvalid = drv_valid && (sel == 2);
  assign s2.tlast  = drv_last;
  assign s2.tuser  = drv_user;
  assign m2.tready = drv_mready;

  axis_frame_pad #(
    .DATA_WIDTH(8), .MIN_FRAME_LEN(60)
  ) u_d0 (
    .clk(clk), .rst(rst), .s_axis(s0), .m_axis(m0)
  );

  axis_frame_pad #(
    .DATA_WIDTH(32), .MIN_FRAME_LEN(60)
  ) u_d1 (
    .clk(clk), .rst(rst), .s_axis(s1), .m_axis(m1)
  );

  axis_frame_pad #(
    .DATA_WIDTH(32), .MIN_FRAME_LEN(62)
  ) u_d2 (
    .clk(clk), .rst(rst), .s_axis(s2), .m_axis(m2)
  );

  always_comb begin
    mon_valid  = m0.tvalid;
    mon_data   = {24'h0, m0.tdata};
    mon_keep   = {3'b0, m0.tkeep};
    mon_last   = m0.tlast;
    mon_user   = m0.tuser;
    mon_sready = s0.tready;
    if (sel == 1) begin
      mon_valid  = m1.tvalid;
      mon_data   = m1.tdata;
      mon_keep   = m1.tkeep;
      mon_last   = m1.tlast;
      mon_user   = m1.tuser;
      mon_sready = s1.tready;
    end else if (sel == 2) begin
      mon_valid  = m2.tvalid;
      mon_data   = m2.tdata;
      mon_keep   = m2.tkeep;
      mon_last   = m2.tlast;
      mon_user   = m2.tuser;
      mon_sready = s2.tready;
    end
  end

  // Model: input beats as sent; short frames become the byte
  // stream extended with zeros to the minimum, re-cut by lanes.
  task automatic add_frame(
    input int         s,
    input logic [7:0] bytes[$],
    input bit         user
  );
    int kw;
    int mn;
    int n;
    logic [7:0] pad[$];
    beat_t t;
    kw = (s == 0) ? 1 : 4;
    mn = (s == 2) ? 62 : 60;
    n  = bytes.size();
    for (int b = 0; b < n; b += kw) begin
      t = '0;
      for (int l = 0; l < kw; l++) begin
        if (b + l < n) begin
          t.data[l*8 +: 8] = bytes[b+l];
          t.keep[l] = 1'b1;
        end else begin
          t.data[l*8 +: 8] = 8'($urandom_range(255));
        end
      end
      t.last = (b + kw >= n);
      t.user = t.last ? user : 1'b0;
      in_q.push_back(t);
      if (n >= mn) exp_q.push_back(t);
    end
    if (n < mn) begin
      pad = bytes;
      while (pad.size() < mn) pad.push_back(8'h00);
      for (int b = 0; b < mn; b += kw) begin
        t = '0;
        for (int l = 0; l < kw; l++) begin
          if (b + l < mn) begin
            t.data[l*8 +: 8] = pad[b+l];
            t.keep[l] = 1'b1;
          end
        end
        t.last = (b + kw >= mn);
        t.user = t.last ? user : 1'b0;
        exp_q.push_back(t);
      end
    end
  endtask

  task automatic add_rand(input int s, input int n, input bit user);
    logic [7:0] q[$];
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255)));
    add_frame(s, q, user);
  endtask

  task automatic run_stream(
    input  int s,
    input  int rdy_pct,
    input  int vld_pct,
    input  int stop_after,
    output int span
  );
    int    bi = 0;
    int    oi = 0;
    int    cyc = 0;
    int    first = -1;
    int    lastc = -1;
    bit    prev_stall = 0;
    bit    in_fire = 0;
    beat_t held = '0;
    beat_t cur;
    sel = s;
    while (oi < exp_q.size() && cyc < LIMIT
           && !(stop_after >= 0 && oi >= stop_after)) begin
      @(negedge clk);
      cyc++;
      if (in_fire) begin
        bi++;
        drv_valid = 1'b0;
        in_fire = 0;
      end
      if (!drv_valid && bi < in_q.size()
          && $urandom_range(99) < vld_pct) begin
        drv_data  = in_q[bi].data;
        drv_keep  = in_q[bi].keep;
        drv_last  = in_q[bi].last;
        drv_user  = in_q[bi].user;
        drv_valid = 1'b1;
      end
      drv_mready = ($urandom_range(99) < rdy_pct);
      #1;
      cur = {mon_data, mon_keep, mon_last, mon_user};
      if (prev_stall) begin
        checks++;
        if (!mon_valid || cur !== held) begin
          errors++;
          $display("FAIL stall_hold beat %0d: got v=%0b %h required %h",
                   oi, mon_valid, cur, held);
        end
      end
      if (mon_valid && drv_mready) begin
        checks++;
        if (cur !== exp_q[oi]) begin
          errors++;
          $display("FAIL out_beat %0d sel %0d: got %h required %h",
                   oi, s, cur, exp_q[oi]);
        end
        if (first < 0) first = cyc;
        lastc = cyc;
        oi++;
      end
      prev_stall = mon_valid && !drv_mready;
      held = cur;
      in_fire = drv_valid && mon_sready;
    end
    checks++;
    if (cyc >= LIMIT) begin
      errors++;
      $display("FAIL timeout sel %0d: got %0d beats required %0d",
               s, oi, exp_q.size());
    end
    @(posedge clk);
    @(negedge clk);
    if (in_fire) bi++;
    drv_valid = 1'b0;
    if (stop_after < 0) begin
      #1;
      checks++;
      if (mon_valid !== 1'b0 || bi != in_q.size()) begin
        errors++;
        $display("FAIL tail sel %0d: got v=%0b in=%0d required v=0 in=%0d",
                 s, mon_valid, bi, in_q.size());
      end
    end
    span = (first < 0) ? 0 : lastc - first + 1;
    in_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv_valid = 1'b0;
    drv_mready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (mon_sready !== 1'b0) begin
        errors++;
        $display("FAIL rst_sready sel %0d: got %b required 0",
                 s, mon_sready);
      end
    end
    rst = 1'b0;
    drv_mready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if ({mon_valid, mon_data, mon_keep, mon_last, mon_user}
          !== '0 || mon_sready !== 1'b1) begin
        errors++;
        $display("FAIL rst_out sel %0d: got v=%b d=%h k=%h l=%b u=%b r=%b required zeros r=1",
                 s, mon_valid, mon_data, mon_keep, mon_last,
                 mon_user, mon_sready);
      end
    end
  endtask

  task automatic test_pad_byte();
    logic [7:0] q[$];
    int span;
    for (int i = 1; i <= 10; i++) q.push_back(8'(i));
    add_frame(0, q, 1'b0);
    run_stream(0, 100, 100, -1, span);
    checks++;
    if (span != 60) begin
      errors++;
      $display("FAIL pad10_span: got %0d required 60", span);
    end
    add_rand(0, 1, 1'b1);
    run_stream(0, 100, 100, -1, span);
    checks++;
    if (span != 60) begin
      errors++;
      $display("FAIL pad1_span: got %0d required 60", span);
    end
  endtask

  task automatic test_pad_wide();
    int span;
    add_rand(1, 5, 1'b0);
    run_stream(1, 100, 100, -1, span);
    checks++;
    if (span != 15) begin
      errors++;
      $display("FAIL pad5_w32_span: got %0d required 15", span);
    end
    add_rand(2, 4, 1'b1);
    run_stream(2, 100, 100, -1, span);
    checks++;
    if (span != 16) begin
      errors++;
      $display("FAIL pad4_min62_span: got %0d required 16", span);
    end
  endtask

  task automatic test_passthru();
    int span;
    add_rand(0, 60, 1'b1);
    add_rand(0, 64, 1'b1);
    run_stream(0, 100, 100, -1, span);
    checks++;
    if (span != 124) begin
      errors++;
      $display("FAIL passthru_span: got %0d required 124", span);
    end
  endtask

  task automatic test_stall();
    logic [7:0] q[$];
    int span;
    for (int i = 1; i <= 10; i++) q.push_back(8'(i));
    add_frame(0, q, 1'b1);
    run_stream(0, 50, 100, -1, span);
    for (int f = 0; f < 8; f++) begin
      add_rand(1, $urandom_range(90, 1), 1'($urandom_range(1)));
    end
    run_stream(1, 60, 70, -1, span);
    for (int f = 0; f < 6; f++) begin
      add_rand(2, $urandom_range(80, 1), 1'($urandom_range(1)));
    end
    run_stream(2, 50, 80, -1, span);
  endtask

  task automatic test_back_to_back();
    int span;
    int n_exp;
    add_rand(1, 3, 1'b1);
    add_rand(1, 70, 1'b0);
    add_rand(1, 1, 1'b0);
    add_rand(1, 60, 1'b1);
    add_rand(1, 5, 1'b1);
    n_exp = exp_q.size();
    run_stream(1, 100, 100, -1, span);
    checks++;
    if (span != n_exp) begin
      errors++;
      $display("FAIL b2b_span: got %0d required %0d", span, n_exp);
    end
  endtask

  task automatic test_reset_pad();
    logic [7:0] q[$];
    int span;
    for (int i = 1; i <= 10; i++) q.push_back(8'(i));
    add_frame(0, q, 1'b1);
    run_stream(0, 100, 100, 20, span);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (mon_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_pad: got valid=%b required 0", mon_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    add_rand(0, 64, 1'b1);
    run_stream(0, 100, 100, -1, span);
    checks++;
    if (span != 64) begin
      errors++;
      $display("FAIL post_rst_span: got %0d required 64", span);
    end
  endtask

  initial begin
    test_reset();
    test_pad_byte();
    test_pad_wide();
    test_passthru();
    test_stall();
    test_back_to_back();
    test_reset_pad();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_frame_pad.md
# axis_frame_pad

AXI-stream frame padder that sits directly upstream of the output decoupling skid-buffer stage in the transmit path. It forwards frames unchanged when they already reach `MIN_FRAME_LEN` bytes. Shorter frames are extended with zero bytes up to exactly `MIN_FRAME_LEN` before `tlast`. Output is registered, so the downstream skid buffer sees a clean, glitch-free handshake.

## Interface
- `DATA_WIDTH`, 8: stream data width in bits; must be a multiple of 8.
- `KEEP_ENABLE`, `(DATA_WIDTH>8)`: propagate tkeep; when 0, input tkeep is treated as all-ones and `m_axis_tkeep` is driven all-ones.
- `KEEP_WIDTH`, `(DATA_WIDTH/8)`: byte lanes per beat.
- `MIN_FRAME_LEN`, 60: minimum output frame length in bytes; must be ≥1.
- `clk` in 1: single clock; all logic is posedge.
- `rst` in 1: synchronous, active-high reset.
- `s_axis_tdata` in DATA_WIDTH: input data.
- `s_axis_tkeep` in KEEP_WIDTH: input byte enables; contiguous from lane 0.
- `s_axis_tvalid` in 1: input valid.
- `s_axis_tready` out 1: input ready.
- `s_axis_tlast` in 1: input end of frame.
- `s_axis_tuser` in 1: input error flag; meaningful on the last beat only.
- `m_axis_tdata` out DATA_WIDTH: output data.
- `m_axis_tkeep` out KEEP_WIDTH: output byte enables.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: output ready.
- `m_axis_tlast` out 1: output end of frame.
- `m_axis_tuser` out 1: output error flag.

## Operation
- **Byte counter.** `byte_cnt` is `$clog2(MIN_FRAME_LEN+1)` bits wide and saturates at `MIN_FRAME_LEN`.
  - Each accepted input beat adds popcount(tkeep).
  - The counter clears on output of a `tlast` beat.
- **State PASS (reset state).** Input beats are copied into the output register.
  - On an accepted `tlast` beat, compute `total = byte_cnt + popcount`.
  - If `total ≥ MIN_FRAME_LEN`: forward the beat unchanged.
  - Else, fill empty lanes of that beat: set the lowest `min(MIN_FRAME_LEN-total, KEEP_WIDTH-popcount)` unused lanes to 0x00 and set their keep bits.
    - If the frame now reaches `MIN_FRAME_LEN`, the beat keeps `tlast`.
    - Otherwise `tlast` is cleared, `tuser` is latched, and the state goes to PAD.
- **State PAD.** `s_axis_tready` is 0.
  - Each output slot emits an all-zero data beat.
  - tkeep is all-ones, or the lowest `MIN_FRAME_LEN-byte_cnt` lanes on the final pad beat.
  - The final pad beat carries `tlast=1` and the latched `tuser`; then the state returns to PASS.
- **tuser.** Forced to 0 on every non-final output beat of a padded frame. Unpadded frames pass tuser through unchanged.
- **Data.** Unpadded frames pass bytes bit-exact. Data in lanes with keep=0 is don't-care on the input and driven 0 on output when padding.
- **Outputs after reset.** `m_axis_tvalid=0`, `s_axis_tready=0` in the reset cycle, and `tlast`, `tuser`, `tkeep`, `tdata` are all 0.

## Timing
- **Latency.** 1 cycle from input acceptance to `m_axis_tvalid`.
- **Ready.** `s_axis_tready = (state==PASS) && (m_axis_tready || !m_axis_tvalid)`.
  - Throughput is one beat per cycle in PASS.
  - This path is combinational from `m_axis_tready`; the downstream skid buffer registers it.
- **Holding.** The output register updates only when `!m_axis_tvalid || m_axis_tready`. While stalled, `m_axis_*` hold stable.
- **PAD back-to-back.** Consecutive pad beats issue back-to-back under continuous ready.
  - The next frame's first beat is accepted in the cycle the final pad beat is consumed.
  - No bubble beyond that.
- **Padding beat count.** A 1-byte frame with `KEEP_WIDTH=1` produces `MIN_FRAME_LEN-1` pad beats.
- **Reset in PAD.** Reset mid-PAD or mid-frame drops the partial frame: state returns to PASS, `byte_cnt` clears, `m_axis_tvalid` is 0 next cycle.
- **Counter width.** The saturating counter must not wrap on frames longer than `2^width` bytes.

## Structure
- Shared stream package/header: `MIN_FRAME_LEN` default (60, Ethernet without FCS) and the `PASS`/`PAD` state encoding constants.
- One sub-module, `keep_popcount`: combinational count of set bits in `KEEP_WIDTH`, output `$clog2(KEEP_WIDTH+1)` bits. It is reused by other length-aware stream blocks.
- The padder feeds `m_axis_*` directly into the skid-buffer stage at the top level.

## Test plan
- `DATA_WIDTH=8`, 10-byte frame 0x01..0x0A, ready=1 → 60 output beats: bytes 1–10 as sent, 50 × 0x00, `tlast` only on beat 60.
- `DATA_WIDTH=32`, 5-byte frame (keep 1111, then 0001 with tlast) → 15 beats. Beat 2 has keep=1111 with lanes 1–3 = 0. Beats 3–15 are zero with keep=1111. `tlast` on beat 15.
- `DATA_WIDTH=32`, `MIN_FRAME_LEN=62`, 4-byte frame → 16 beats; beat 16 has keep=0011 and tlast.
- 60-byte and 64-byte frames, `DATA_WIDTH=8` → pass through bit-exact. `tuser=1` on the input last beat appears on the output last beat only.
- 10-byte frame with `tuser=1`, random `m_axis_tready` (50%) → same 60-byte output as scenario 1, `tuser=1` only on the final beat, no beat lost or duplicated, outputs stable while stalled.
- Assert `rst` for 1 cycle during PAD (after 20 output beats) → next cycle `m_axis_tvalid=0`; a following 64-byte frame passes unchanged.
